// File: rtl/fir_coeff_pkg.sv
// Shared definitions for the FIR coefficient path: frame header, loader state
// encoding and coefficient-count helpers also used by the filter itself.
package fir_coeff_pkg;

    localparam logic [7:0] HEADER = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE  = 2'd1,
        WRITE = 2'd2,
        CHK   = 2'd3
    } state_t;

    // Number of stored coefficients for a symmetric filter of order ord.
    function automatic int unsigned nc_of(input int unsigned ord);
        return (ord + 1) / 2;
    endfunction

    function automatic int unsigned addr_w_of(input int unsigned ord);
        int unsigned nc;
        nc = nc_of(ord);
        return (nc > 1) ? $clog2(nc) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Assembles MSB-first coefficient bytes from a framed valid/ready stream and
// writes them to the filter coefficient port, checking a trailing XOR checksum.
module fir_coeff_loader
    import fir_coeff_pkg::*;
#(
    parameter int unsigned ORD = 256,
    parameter int unsigned C   = 16,
    parameter int unsigned TMO = 1024
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [7:0]                 s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       c_WE,
    output logic [C-1:0]               c_in,
    output logic [addr_w_of(ORD)-1:0]  c_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned NC    = nc_of(ORD);
    localparam int unsigned AW    = addr_w_of(ORD);
    localparam int unsigned BYTES = C / 8;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TW    = $clog2(TMO + 1);

    state_t        state;
    logic [BW-1:0] byte_cnt;
    logic [AW-1:0] addr_cnt;
    logic [C-1:0]  asm_word;
    logic [7:0]    csum;
    logic [TW-1:0] tmo_cnt;

    logic          accept;
    logic          tmo_hit;
    logic [C-1:0]  asm_next;

    // Only the single write cycle back-pressures the stream.
    assign s_ready  = (state != WRITE);
    assign accept   = s_valid && s_ready;
    // An accepted byte in the expiry cycle wins over the timeout.
    assign tmo_hit  = (state != IDLE) && !accept && (tmo_cnt == TW'(TMO - 1));
    assign asm_next = C'({asm_word, s_data});

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            addr_cnt <= '0;
            asm_word <= '0;
            csum     <= '0;
            tmo_cnt  <= '0;
            c_WE     <= 1'b0;
            c_in     <= '0;
            c_addr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            c_WE <= 1'b0;
            done <= 1'b0;

            if (state == IDLE || accept || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (tmo_hit) begin
                state <= IDLE;
                busy  <= 1'b0;
                err   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && s_data == HEADER) begin
                            err      <= 1'b0;
                            addr_cnt <= '0;
                            byte_cnt <= '0;
                            csum     <= '0;
                            state    <= BYTE;
                            busy     <= 1'b1;
                        end
                    end
                    BYTE: begin
                        if (accept) begin
                            asm_word <= asm_next;
                            csum     <= csum ^ s_data;
                            if (byte_cnt == BW'(BYTES - 1)) begin
                                // Strobe is launched here so it is visible in the WRITE cycle.
                                byte_cnt <= '0;
                                state    <= WRITE;
                                c_WE     <= 1'b1;
                                c_in     <= asm_next;
                                c_addr   <= addr_cnt;
                            end else begin
                                byte_cnt <= byte_cnt + BW'(1);
                            end
                        end
                    end
                    WRITE: begin
                        addr_cnt <= addr_cnt + AW'(1);
                        state    <= (addr_cnt == AW'(NC - 1)) ? CHK : BYTE;
                    end
                    CHK: begin
                        if (accept) begin
                            if (s_data == csum) begin
                                done <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a 16-bit default instance and an 8-bit
// short-frame instance, checked every cycle against a frame-level model.
module tb_fir_coeff_loader;

    localparam int NC0  = 128;
    localparam int B0   = 2;
    localparam int TMO0 = 1024;
    localparam int NC1  = 8;
    localparam int B1   = 1;
    localparam int TMO1 = 8;

    typedef bit [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [1:0] sv;
    logic [7:0] sd [2];

    logic        s_ready0, c_we0, busy0, done0, err0;
    logic [15:0] c_in0;
    logic [6:0]  c_addr0;
    logic        s_ready1, c_we1, busy1, done1, err1;
    logic [7:0]  c_in1;
    logic [2:0]  c_addr1;

    logic [1:0]  d_rdy, d_we, d_busy, d_done, d_err;
    logic [31:0] d_cin  [2];
    logic [31:0] d_addr [2];

    assign d_rdy     = {s_ready1, s_ready0};
    assign d_we      = {c_we1, c_we0};
    assign d_busy    = {busy1, busy0};
    assign d_done    = {done1, done0};
    assign d_err     = {err1, err0};
    assign d_cin[0]  = 32'(c_in0);
    assign d_cin[1]  = 32'(c_in1);
    assign d_addr[0] = 32'(c_addr0);
    assign d_addr[1] = 32'(c_addr1);

    fir_coeff_loader #(.ORD(256), .C(16), .TMO(TMO0)) u_dut0 (
        .clk(clk), .nrst(nrst), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(s_ready0),
        .c_WE(c_we0), .c_in(c_in0), .c_addr(c_addr0), .busy(busy0), .done(done0), .err(err0)
    );

    fir_coeff_loader #(.ORD(15), .C(8), .TMO(TMO1)) u_dut1 (
        .clk(clk), .nrst(nrst), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(s_ready1),
        .c_WE(c_we1), .c_in(c_in1), .c_addr(c_addr1), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    function automatic int nc_i(input int i);
        return (i == 0) ? NC0 : NC1;
    endfunction
    function automatic int by_i(input int i);
        return (i == 0) ? B0 : B1;
    endfunction
    function automatic int tmo_i(input int i);
        return (i == 0) ? TMO0 : TMO1;
    endfunction

    // Frame-level model: position in frame, running XOR, idle-cycle count.
    bit [1:0]  m_busy, e_we, e_done, e_err;
    int        m_pos [2];
    int        m_idle [2];
    bit [31:0] m_word [2];
    bit [7:0]  m_csum [2];
    bit [31:0] e_in [2];
    int        e_addr [2];

    always @(posedge clk or negedge nrst) begin
        bit        acc;
        bit [31:0] w;
        if (!nrst) begin
            m_busy <= '0; e_we <= '0; e_done <= '0; e_err <= '0;
            for (int i = 0; i < 2; i++) begin
                m_pos[i] <= 0; m_idle[i] <= 0; m_word[i] <= '0; m_csum[i] <= '0;
                e_in[i] <= '0; e_addr[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                acc = sv[i] && !e_we[i];
                e_we[i]   <= 1'b0;
                e_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (acc && sd[i] == 8'hA5) begin
                        m_busy[i] <= 1'b1; m_pos[i] <= 0; m_csum[i] <= '0;
                        m_idle[i] <= 0;    e_err[i] <= 1'b0;
                    end
                end else if (acc) begin
                    m_idle[i] <= 0;
                    if (m_pos[i] == nc_i(i) * by_i(i)) begin
                        if (sd[i] == m_csum[i]) e_done[i] <= 1'b1;
                        else                    e_err[i]  <= 1'b1;
                        m_busy[i] <= 1'b0;
                    end else begin
                        w = (m_pos[i] % by_i(i) == 0) ? 32'(sd[i]) : ((m_word[i] << 8) | 32'(sd[i]));
                        m_word[i] <= w;
                        m_csum[i] <= m_csum[i] ^ sd[i];
                        m_pos[i]  <= m_pos[i] + 1;
                        if ((m_pos[i] + 1) % by_i(i) == 0) begin
                            e_we[i]   <= 1'b1;
                            e_in[i]   <= w;
                            e_addr[i] <= m_pos[i] / by_i(i);
                        end
                    end
                end else if (m_idle[i] + 1 >= tmo_i(i)) begin
                    m_busy[i] <= 1'b0;
                    e_err[i]  <= 1'b1;
                end else begin
                    m_idle[i] <= m_idle[i] + 1;
                end
            end
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc_no = 0;
    logic [1:0]  rdy_seen;
    int          wr_cnt [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          prev_we1 = -1;
    logic [31:0] cap5 = '0;
    int          first_addr0 = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d c_WE", i),    32'(d_we[i]),   32'(e_we[i]));
            chk($sformatf("i%0d s_ready", i), 32'(d_rdy[i]),  32'(!e_we[i]));
            chk($sformatf("i%0d busy", i),    32'(d_busy[i]), 32'(m_busy[i]));
            chk($sformatf("i%0d done", i),    32'(d_done[i]), 32'(e_done[i]));
            chk($sformatf("i%0d err", i),     32'(d_err[i]),  32'(e_err[i]));
            chk($sformatf("i%0d c_in", i),    d_cin[i],       e_in[i]);
            chk($sformatf("i%0d c_addr", i),  d_addr[i],      32'(e_addr[i]));
            if (d_we[i] === 1'b1) wr_cnt[i]++;
            if (d_done[i] === 1'b1) done_cnt[i]++;
        end
        if (d_we[0] === 1'b1 && d_addr[0] == 32'd5) cap5 = d_cin[0];
        if (d_we[0] === 1'b1 && first_addr0 < 0) first_addr0 = int'(d_addr[0]);
        if (d_we[1] === 1'b1) begin
            if (prev_we1 >= 0) chk("i1 write spacing", 32'(cyc_no - prev_we1), 32'd2);
            prev_we1 = cyc_no;
        end
    endtask

    // One clock: compare at the falling edge, then step past the rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        rdy_seen = d_rdy;
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_byte(input int i, input logic [7:0] b);
        int n = 0;
        sv[i] = 1'b1;
        sd[i] = b;
        do begin
            cyc();
            n++;
        end while (!rdy_seen[i] && n < 16);
        chk($sformatf("i%0d handshake", i), 32'(rdy_seen[i]), 32'd1);
    endtask

    task automatic send_q(input int i, input bq_t q, input int from, input int upto,
                          input int stall_idx, input int stall_len);
        for (int k = from; k < upto; k++) begin
            if (k == stall_idx) begin
                sv[i] = 1'b0;
                repeat (stall_len) cyc();
            end
            send_byte(i, q[k]);
        end
        sv[i] = 1'b0;
    endtask

    // mode 1 places an 8'hA5 data byte pattern mid-frame.
    function automatic bq_t make_frame(input int i, input int mode, input bit [7:0] chk_xor);
        bq_t       q;
        bit [7:0]  cs;
        bit [15:0] c;
        cs = '0;
        q.push_back(8'hA5);
        for (int k = 0; k < nc_i(i); k++) begin
            if (by_i(i) == 2) c = (mode == 1 && k == 5) ? 16'hA5A5 : 16'h0100 + 16'(k);
            else              c = (mode == 1 && k == 3) ? 16'h00A5 : 16'h0010 + 16'(k);
            for (int b = by_i(i) - 1; b >= 0; b--) begin
                bit [7:0] v;
                v = 8'(c >> (8 * b));
                q.push_back(v);
                cs ^= v;
            end
        end
        q.push_back(cs ^ chk_xor);
        return q;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t q;
        int  w0, dn0;
        sv = '0;
        sd[0] = '0;
        sd[1] = '0;
        #1 nrst = 1'b0;
        idle(3);
        nrst = 1'b1;
        chk("reset busy",    32'(busy0),    32'd0);
        chk("reset err",     32'(err0),     32'd0);
        chk("reset c_WE",    32'(c_we0),    32'd0);
        chk("reset s_ready", 32'(s_ready0), 32'd1);
        chk("reset c_in",    32'(c_in0),    32'd0);
        chk("reset c_addr",  32'(c_addr0),  32'd0);
        idle(2);

        // Garbage before a header is swallowed.
        send_byte(0, 8'h00);
        send_byte(0, 8'hFF);
        send_byte(0, 8'h5A);
        sv[0] = 1'b0;
        idle(2);
        chk("garbage writes", 32'(wr_cnt[0]), 32'd0);
        chk("garbage busy",   32'(busy0),     32'd0);

        // Good default frame, continuous valid.
        q = make_frame(0, 0, 8'h00);
        chk("good frame checksum byte", 32'(q[q.size() - 1]), 32'h00);
        send_q(0, q, 0, q.size(), -1, 0);
        idle(2);
        chk("good writes",      32'(wr_cnt[0]),   32'd128);
        chk("good done count",  32'(done_cnt[0]), 32'd1);
        chk("good err",         32'(err0),        32'd0);
        chk("good last c_in",   32'(c_in0),       32'h017F);
        chk("good last c_addr", 32'(c_addr0),     32'd127);

        // Corrupted checksum.
        w0 = wr_cnt[0]; dn0 = done_cnt[0];
        q = make_frame(0, 0, 8'h01);
        send_q(0, q, 0, q.size(), -1, 0);
        idle(2);
        chk("badchk writes", 32'(wr_cnt[0] - w0),   32'd128);
        chk("badchk done",   32'(done_cnt[0] - dn0), 32'd0);
        chk("badchk err",    32'(err0),              32'd1);

        // Next header clears err; A5 data mid-frame is ordinary data.
        w0 = wr_cnt[0]; dn0 = done_cnt[0];
        cap5 = '0;
        q = make_frame(0, 1, 8'h00);
        send_q(0, q, 0, 1, -1, 0);
        chk("header clears err", 32'(err0),  32'd0);
        chk("header sets busy",  32'(busy0), 32'd1);
        send_q(0, q, 1, q.size(), -1, 0);
        idle(2);
        chk("A5 data c_in",   cap5,                   32'hA5A5);
        chk("A5 frame done",  32'(done_cnt[0] - dn0), 32'd1);
        chk("A5 frame writes", 32'(wr_cnt[0] - w0),   32'd128);

        // Stall of TMO-1 idle cycles after 10 coefficients survives.
        dn0 = done_cnt[0];
        q = make_frame(0, 0, 8'h00);
        send_q(0, q, 0, q.size(), 1 + 10 * B0, TMO0 - 1);
        idle(2);
        chk("stall TMO-1 done", 32'(done_cnt[0] - dn0), 32'd1);
        chk("stall TMO-1 err",  32'(err0),              32'd0);

        // Stall of TMO idle cycles times out.
        w0 = wr_cnt[0]; dn0 = done_cnt[0];
        send_q(0, q, 0, 1 + 10 * B0, -1, 0);
        idle(TMO0 - 1);
        chk("pre-timeout busy", 32'(busy0), 32'd1);
        idle(1);
        chk("timeout busy",   32'(busy0),              32'd0);
        chk("timeout err",    32'(err0),               32'd1);
        idle(2);
        chk("timeout writes", 32'(wr_cnt[0] - w0),     32'd10);
        chk("timeout done",   32'(done_cnt[0] - dn0),  32'd0);

        // Reset during coefficient 50, then a clean reload from address 0.
        w0 = wr_cnt[0];
        send_q(0, q, 0, 1 + 50 * B0 + 1, -1, 0);
        chk("pre-reset writes", 32'(wr_cnt[0] - w0), 32'd50);
        nrst = 1'b0;
        #1;
        chk("mid reset busy",   32'(busy0),   32'd0);
        chk("mid reset c_addr", 32'(c_addr0), 32'd0);
        chk("mid reset c_in",   32'(c_in0),   32'd0);
        idle(2);
        nrst = 1'b1;
        idle(1);
        w0 = wr_cnt[0]; dn0 = done_cnt[0];
        first_addr0 = -1;
        send_q(0, q, 0, q.size(), -1, 0);
        idle(2);
        chk("post-reset first addr", 32'(first_addr0),         32'd0);
        chk("post-reset writes",     32'(wr_cnt[0] - w0),      32'd128);
        chk("post-reset done",       32'(done_cnt[0] - dn0),   32'd1);

        // 8-bit instance streaming: one write every 2 cycles.
        q = make_frame(1, 1, 8'h00);
        send_q(1, q, 0, q.size(), -1, 0);
        idle(3);
        chk("c8 writes",      32'(wr_cnt[1]),   32'd8);
        chk("c8 done",        32'(done_cnt[1]), 32'd1);
        chk("c8 err",         32'(err1),        32'd0);
        chk("c8 last c_in",   32'(c_in1),       32'h17);
        chk("c8 last c_addr", 32'(c_addr1),     32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient-load initiator for the FIR lowpass filter. It receives a framed byte stream over a valid/ready handshake and assembles C-bit coefficients. It drives the filter's c_WE/c_in/c_addr write port with one single-cycle write per coefficient, in ascending address order. The block checks a trailing XOR checksum, applies an idle timeout, and reports busy/done/err to the host side.

## Interface
- ORD, 256: filter order; number of coefficients NC = (ORD+1)/2 (integer division, 128 at default).
- C, 16: coefficient width; legal values 8, 16, 24, 32; BYTES = C/8.
- TMO, 1024: idle timeout in clk cycles, must be at least 4.
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader can accept a byte
- c_WE  out  1  coefficient write strobe to the filter, one cycle per coefficient
- c_in  out  C  coefficient value, valid while c_WE=1
- c_addr  out  clog2(NC)  coefficient address, valid while c_WE=1
- busy  out  1  frame in progress (state not IDLE)
- done  out  1  one-cycle pulse: frame completed with checksum match
- err  out  1  sticky: checksum mismatch or timeout; cleared when the next header is accepted

## Operation
- Handshake: a byte is accepted on a rising clk edge when s_valid and s_ready are both 1. s_ready is combinational from state: 1 in IDLE, BYTE and CHK; 0 in WRITE.
- Frame format: header 8'hA5, then NC coefficients, each BYTES bytes MSB-first, then one checksum byte. The checksum is the XOR of all coefficient bytes; the header is excluded.
- IDLE: bytes other than 8'hA5 are accepted and discarded. On an accepted 8'hA5 the block clears err, the address counter, the byte counter and the checksum accumulator, then enters BYTE.
- BYTE: each accepted byte is shifted into the assembly register (shift left by 8) and XORed into the accumulator. After the BYTES-th byte the block enters WRITE. Inside a frame, 8'hA5 is ordinary data.
- WRITE: lasts exactly one cycle with c_WE=1, c_in = assembled word and c_addr = address counter. Next cycle the address increments. If the address just written was NC-1 the block enters CHK; otherwise it returns to BYTE.
- CHK: on an accepted byte, if it equals the accumulator, done pulses; otherwise err is set. The block returns to IDLE in both cases.
- Timeout: the counter resets on every accepted byte and counts in every non-IDLE state. When it reaches TMO the block sets err, returns to IDLE and does not pulse done. Coefficients already written stay written.
- If a byte is accepted in the same cycle the counter would hit TMO, the byte wins: it is consumed and the counter resets.
- A checksum mismatch or timeout leaves the filter partially or wrongly loaded. The host must resend the whole frame.

## Timing
- Reset values: state IDLE, s_ready 1, c_WE 0, c_in 0, c_addr 0, busy 0, done 0, err 0, all counters 0.
- When the last byte of a coefficient is accepted at edge t, c_WE, c_in and c_addr are valid in cycle t+1. The next byte can be accepted at edge t+2.
- c_in and c_addr hold their last written value when c_WE=0.
- Maximum throughput is BYTES+1 cycles per coefficient.
- When the checksum byte is accepted at edge t, done or err is valid in cycle t+1 and busy drops in cycle t+1.
- A full default frame (128 coefficients, 16-bit) takes at least 1 + 128*3 + 1 = 386 cycles.
- nrst asserted mid-frame returns every output to its reset value immediately, with no further c_WE. Reset does not touch the filter's coefficient memory.

## Structure
- Shared package fir_coeff_pkg holds: header constant 8'hA5, state encoding (IDLE, BYTE, WRITE, CHK), and NC/address-width helper functions reused by fir.
- Single module. The timeout counter, byte counter, address counter and assembly register are inline; no sub-module is warranted.

## Test plan
- Good frame with defaults, coefficient k = 16'h0100+k: 128 c_WE pulses with c_addr 0..127 and matching c_in; done pulses once; err stays 0.
- Same frame with the checksum byte XORed by 8'h01: all 128 writes occur, done stays 0, err=1; the next 8'hA5 header clears err.
- Garbage 8'h00, 8'hFF, 8'h5A before the header: no c_WE and busy stays 0. Mid-frame 8'hA5 data byte: written as data, e.g. c_in 16'hA5A5 at its address.
- Stall of TMO cycles after 10 coefficients: err=1, busy=0, no done, exactly 10 writes seen. Stall of TMO-1 cycles: the frame completes normally.
- nrst pulsed during coefficient 50: outputs return to reset values. A following complete frame loads from address 0 and pulses done.
- s_valid held high continuously: s_ready low exactly in each WRITE cycle, no byte lost or duplicated; C=8 instance (BYTES=1) gives one write every 2 cycles.
